instruction_prefetch: RTL and testbench
=======================================

INSTRUCTION_PREFETCH -- requirements
Module: instruction_prefetch

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of fetch-buffer entries (power of two, 2 to 16).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port imem_req, output, 1 bit: fetch request to instruction memory.
REQ-006 The block SHALL have port imem_addr, output, 32 bits: fetch address, valid while imem_req=1.
REQ-007 The block SHALL have port imem_gnt, input, 1 bit: memory accepts the request this cycle.
REQ-008 The block SHALL have port imem_rvalid, input, 1 bit: response data valid.
REQ-009 The block SHALL have port imem_rdata, input, 32 bits: fetched instruction word.
REQ-010 The block SHALL have port redirect, input, 1 bit: branch/jump flush from the execute/write-back stage.
REQ-011 The block SHALL have port redirect_pc, input, 32 bits: new fetch target.
REQ-012 The block SHALL have port if_valid, output, 1 bit: buffer head holds a valid instruction for decode.
REQ-013 The block SHALL have port if_ready, input, 1 bit: decode consumes the head this cycle.
REQ-014 The block SHALL have port if_ir, output, 32 bits: head instruction word.
REQ-015 The block SHALL have port if_pc, output, 32 bits: head instruction address.
REQ-016 The block SHALL have port if_npc, output, 32 bits: if_pc+4, modulo 2^32.

Function
REQ-017 The FSM SHALL have states IDLE (no request outstanding), WAIT (one granted request outstanding) and DROP (outstanding response to be discarded).
REQ-018 In IDLE, imem_req SHALL be 1 iff count<DEPTH and redirect=0; imem_addr SHALL equal fetch_pc.
REQ-019 IDLE with imem_req=1 and imem_gnt=1 SHALL move to WAIT and set fetch_pc=fetch_pc+4 (wraps at 2^32); imem_req SHALL be 0 in WAIT and DROP.
REQ-020 WAIT with imem_rvalid=1 SHALL push {pc, imem_rdata} into the buffer and return to IDLE; a push cannot overflow, because space is reserved at request time.
REQ-021 Pop SHALL occur when if_valid=1 and if_ready=1; simultaneous push and pop SHALL leave count unchanged.
REQ-022 if_valid SHALL equal (count!=0) and redirect=0; if_ir, if_pc and if_npc SHALL be 0 when count=0.
REQ-023 redirect=1 SHALL, at the next edge, empty the buffer, set fetch_pc={redirect_pc[31:2],2'b00}, and set state to DROP if in WAIT (or WAIT with rvalid=0); it SHALL have priority over push, pop and grant.
REQ-024 redirect in WAIT coincident with imem_rvalid=1 SHALL discard that data and go to IDLE.
REQ-025 DROP with imem_rvalid=1 SHALL discard the data and go to IDLE; redirect in DROP SHALL update fetch_pc and stay in DROP.
REQ-026 Latency: grant in cycle N and rvalid in cycle N+1 SHALL give if_valid=1 in cycle N+2; peak throughput is one instruction per 2 cycles.

Reset
REQ-027 While rst=0: state=IDLE, fetch_pc=RESET_PC, count=0, pointers=0, imem_req=0, if_valid=0, if_ir, if_pc and if_npc=0.
REQ-028 Reset asserted mid-transaction SHALL abandon the outstanding request; the memory model SHALL also be reset.
REQ-029 In the first cycle after rst rises, imem_req=1 and imem_addr=RESET_PC.

Structure
REQ-030 A shared package fetch_pkg SHALL hold XLEN=32, the RESET_PC default, the state encoding (IDLE/WAIT/DROP) and the 64-bit entry layout {pc, ir}.
REQ-031 The storage SHALL be one sub-module, fetch_fifo (synchronous FIFO with flush, push, pop and count), and the FSM and PC logic SHALL be in instruction_prefetch.

Verification
REQ-032 Release reset, memory grants immediately with 1-cycle rvalid, if_ready=1 -> addresses 0x0,0x4,0x8 requested; if_pc/if_ir track in order; if_npc=if_pc+4.
REQ-033 if_ready=0 with DEPTH=4 -> exactly 4 grants, then imem_req=0; count=4; one pop -> imem_req=1 the next cycle.
REQ-034 redirect=1 with redirect_pc=0x0000_0102 while in WAIT -> late rvalid discarded, next imem_addr=0x0000_0100, buffer empty, if_valid=0 during redirect.
REQ-035 fetch_pc=0xFFFF_FFFC granted -> entry if_pc=0xFFFF_FFFC, if_npc=0x0000_0000, next imem_addr=0x0000_0000.
REQ-036 rst driven low in WAIT -> all outputs 0 immediately (asynchronous); after release, imem_addr=RESET_PC.
REQ-037 Redirect coincident with push and pop on a full buffer -> count=0 and new target fetched, with no stale instruction ever presented.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction prefetch slice: fetch FSM encoding and the
// {pc, ir} fetch-buffer entry layout.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ir;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous fetch buffer with flush, push, pop and occupancy count; the head
// entry is visible combinationally so a pushed word reaches decode next cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // Flush wins over everything; a pop is only honoured on a non-empty buffer.
  assign do_pop  = pop && !flush && (count_q != '0);
  assign do_push = push && !flush && ((count_q != FULL) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instruction_prefetch.sv
// Single-outstanding instruction prefetcher: issues word fetches, buffers the
// responses with their PCs, and flushes/retargets on a redirect.
module instruction_prefetch
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_ir,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_npc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;

  logic            fifo_push, fifo_pop;
  fetch_entry_t    fifo_head, push_entry;
  logic [CW-1:0]   fifo_count;
  logic            buf_nonempty;

  assign buf_nonempty = (fifo_count != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    if (redirect) begin
      fetch_pc_d = word_align(redirect_pc);
      // A request still in flight must have its response swallowed.
      if (state_q != ST_IDLE) state_d = imem_rvalid ? ST_IDLE : ST_DROP;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (imem_req && imem_gnt) begin
            state_d    = ST_WAIT;
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end
        ST_WAIT: if (imem_rvalid) state_d = ST_IDLE;
        ST_DROP: if (imem_rvalid) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    imem_req  = rst && (state_q == ST_IDLE) && (fifo_count < FULL) && !redirect;
    imem_addr = fetch_pc_q;
    fifo_push = (state_q == ST_WAIT) && imem_rvalid && !redirect;
    if_valid  = buf_nonempty && !redirect;
    fifo_pop  = if_valid && if_ready;
    if_ir     = buf_nonempty ? fifo_head.ir : '0;
    if_pc     = buf_nonempty ? fifo_head.pc : '0;
    if_npc    = buf_nonempty ? fifo_head.pc + 32'd4 : '0;
  end

  assign push_entry = '{pc: req_pc_q, ir: imem_rdata};

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect),
    .push     (fifo_push),
    .push_data(push_entry),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_instruction_prefetch.sv
// Randomized bench for instruction_prefetch: a queue-based model of the fetch
// stream plus a one-outstanding memory responder with random latency.
module tb_instruction_prefetch;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid, if_ready;
  logic [31:0] if_ir, if_pc, if_npc;

  instruction_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_ir      (if_ir),
    .if_pc      (if_pc),
    .if_npc     (if_npc)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: in-order list of {pc, ir} entries, next fetch address, and one
  // owed memory response that may have been cancelled by a redirect.
  logic [63:0] mdl_q[$];
  logic [31:0] mdl_fetch_pc;
  logic        mdl_pending;
  logic        mdl_cancelled;
  logic [31:0] mdl_req_pc;

  int          p_gnt, p_rv, p_ready, p_redir;
  logic        rpc_force;
  logic [31:0] rpc_val;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5A17;
  endfunction

  function automatic logic [31:0] pick_target();
    case ($urandom_range(3))
      0:       return 32'h0000_0102;
      1:       return 32'hFFFF_FFFC;
      2:       return 32'hFFFF_FFF0 | ($urandom & 32'hF);
      default: return $urandom;
    endcase
  endfunction

  task automatic model_reset();
    mdl_q.delete();
    mdl_fetch_pc  = RESET_PC;
    mdl_pending   = 1'b0;
    mdl_cancelled = 1'b0;
    mdl_req_pc    = '0;
  endtask

  task automatic step();
    logic        exp_req, exp_valid, popped;
    logic [31:0] exp_pc, exp_ir, exp_npc;
    @(negedge clk);
    if_ready = ($urandom_range(99) < p_ready);
    imem_gnt = ($urandom_range(99) < p_gnt);
    redirect = rpc_force || ($urandom_range(99) < p_redir);
    redirect_pc = rpc_force ? rpc_val : pick_target();
    if (mdl_pending && ($urandom_range(99) < p_rv)) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mdl_req_pc);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    exp_req   = !mdl_pending && (mdl_q.size() < DEPTH) && !redirect;
    exp_valid = (mdl_q.size() != 0) && !redirect;
    exp_pc    = (mdl_q.size() != 0) ? mdl_q[0][63:32] : 32'h0;
    exp_ir    = (mdl_q.size() != 0) ? mdl_q[0][31:0] : 32'h0;
    exp_npc   = (mdl_q.size() != 0) ? exp_pc + 32'd4 : 32'h0;
    check("imem_req", {31'h0, imem_req}, {31'h0, exp_req});
    if (exp_req) check("imem_addr", imem_addr, mdl_fetch_pc);
    check("if_valid", {31'h0, if_valid}, {31'h0, exp_valid});
    check("if_pc", if_pc, exp_pc);
    check("if_ir", if_ir, exp_ir);
    check("if_npc", if_npc, exp_npc);
    @(posedge clk);
    popped = exp_valid && if_ready;
    if (redirect) begin
      mdl_q.delete();
      mdl_fetch_pc = {redirect_pc[31:2], 2'b00};
      if (mdl_pending) begin
        if (imem_rvalid) begin
          mdl_pending   = 1'b0;
          mdl_cancelled = 1'b0;
        end else begin
          mdl_cancelled = 1'b1;
        end
      end
    end else begin
      if (popped) void'(mdl_q.pop_front());
      if (mdl_pending && imem_rvalid) begin
        if (!mdl_cancelled) mdl_q.push_back({mdl_req_pc, imem_rdata});
        mdl_pending   = 1'b0;
        mdl_cancelled = 1'b0;
      end else if (exp_req && imem_gnt) begin
        mdl_pending  = 1'b1;
        mdl_req_pc   = mdl_fetch_pc;
        mdl_fetch_pc = mdl_fetch_pc + 32'd4;
      end
    end
  endtask

  task automatic run_phase(input string name, input int g, input int rv, input int rdy,
                           input int rd, input int n);
    p_gnt = g; p_rv = rv; p_ready = rdy; p_redir = rd;
    for (int i = 0; i < n; i++) step();
    $display("phase %s: %0d cycles, %0d vectors, %0d miscompares so far", name, n, n_vec, n_err);
  endtask

  task automatic force_redirect(input logic [31:0] target);
    rpc_force = 1'b1;
    rpc_val   = target;
    step();
    rpc_force = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; if_ready = 1'b0;
    #1;
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_valid", {31'h0, if_valid}, 32'h0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_ir", if_ir, 32'h0);
    check("rst_npc", if_npc, 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_rst_req", {31'h0, imem_req}, 32'h1);
    check("post_rst_addr", imem_addr, RESET_PC);
  endtask

  initial begin
    int guard;
    rpc_force = 1'b0;
    rpc_val   = '0;
    rst = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; if_ready = 1'b0;
    model_reset();
    do_reset();

    run_phase("stream", 100, 100, 100, 0, 30);
    run_phase("fill", 100, 100, 0, 0, 20);
    run_phase("drain_one", 100, 100, 30, 0, 10);
    run_phase("fill_again", 100, 100, 0, 0, 12);
    force_redirect(32'h0000_0102);
    run_phase("after_full_redirect", 100, 100, 100, 0, 10);

    // Redirect while a response is owed, then deliver it late.
    p_gnt = 100; p_rv = 0; p_ready = 100; p_redir = 0;
    guard = 0;
    while (!mdl_pending && guard < 20) begin step(); guard++; end
    check("wait_reached", {31'h0, mdl_pending}, 32'h1);
    force_redirect(32'h0000_0102);
    run_phase("late_rvalid", 100, 60, 100, 0, 15);

    force_redirect(32'hFFFF_FFFC);
    run_phase("wrap", 100, 100, 100, 0, 12);

    run_phase("random", 70, 60, 60, 10, 600);
    run_phase("redirect_heavy", 80, 50, 50, 40, 300);

    p_gnt = 100; p_rv = 0; p_ready = 50; p_redir = 0;
    guard = 0;
    while (!mdl_pending && guard < 20) begin step(); guard++; end
    check("wait_before_reset", {31'h0, mdl_pending}, 32'h1);
    do_reset();
    run_phase("after_reset", 90, 70, 70, 5, 200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
